// File: rtl/layer_compositor.sv
// layer_compositor: fixed-priority merge of NUM_LAYERS drawing layers over a
// background colour, followed by a frame-stepped fade engine for screen
// transitions. Layer 0 has the highest priority.
// Two-stage pipeline: stage 1 picks the winning layer, stage 2 scales the
// colour by the fade level (0..16, where 16 means the colour passes unchanged).
// Optional feature: define LAYER_COLLISION_DETECT_EN to add the collision_map
// output, which gives a per-frame record of which layers overlapped.
module layer_compositor #(
    parameter int NUM_LAYERS  = 8,
    parameter int CH_W        = 4,
    parameter int FADE_FRAMES = 2,
    localparam int RGB_W      = 3 * CH_W,
    localparam int IDX_W      = $clog2(NUM_LAYERS) + 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start_of_frame,
    input  logic [NUM_LAYERS-1:0]       layer_dr,
    input  logic [NUM_LAYERS*RGB_W-1:0] layer_rgb,
    input  logic [RGB_W-1:0]            background_rgb,
    input  logic [NUM_LAYERS-1:0]       layer_en_next,
    input  logic                        fade_req,
    input  logic                        fade_release,
    output logic [CH_W-1:0]             red_level,
    output logic [CH_W-1:0]             green_level,
    output logic [CH_W-1:0]             blue_level,
    output logic [IDX_W-1:0]            top_layer,
    output logic                        fade_black,
    output logic                        fade_done
`ifdef LAYER_COLLISION_DETECT_EN
    ,
    output logic [NUM_LAYERS-1:0]       collision_map
`endif
);

    typedef enum logic [1:0] {IDLE, FADE_OUT, BLACK, FADE_IN} fade_state_t;

    localparam int CNT_W = $clog2(FADE_FRAMES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FADE_FRAMES - 1);
    localparam logic [IDX_W-1:0] BG_IDX   = IDX_W'(NUM_LAYERS);

    fade_state_t           state;
    logic [4:0]            level;
    logic [CNT_W-1:0]      frame_cnt;
    logic [NUM_LAYERS-1:0] mask_q;
    logic [NUM_LAYERS-1:0] eff_mask;
    logic [NUM_LAYERS-1:0] active;
    logic [RGB_W-1:0]      win_rgb;
    logic [IDX_W-1:0]      win_idx;
    logic [RGB_W-1:0]      sel_rgb;
    logic [IDX_W-1:0]      sel_idx;

    // The mask arriving with start_of_frame already applies to pixel (0,0).
    assign eff_mask = start_of_frame ? layer_en_next : mask_q;
    assign active   = layer_dr & eff_mask;

    // Scale one channel by the fade level; level 16 reproduces the input.
    function automatic logic [CH_W-1:0] scale(input logic [CH_W-1:0] c,
                                              input logic [4:0] lvl);
        logic [CH_W+4:0] prod;
        prod = {5'b0, c} * {{CH_W{1'b0}}, lvl};
        return prod[CH_W+3:4];
    endfunction

    // Latch the enable mask for the coming frame.
    always_ff @(posedge clk) begin
        if (reset)
            mask_q <= '1;
        else if (start_of_frame)
            mask_q <= layer_en_next;
    end

    // Priority pick: scanning from the top index down leaves the lowest active layer.
    always_comb begin
        win_rgb = background_rgb;
        win_idx = BG_IDX;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (active[i]) begin
                win_rgb = layer_rgb[i*RGB_W +: RGB_W];
                win_idx = IDX_W'(i);
            end
        end
    end

    // Stage 1: register the winning colour and its layer index.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_rgb <= '0;
            sel_idx <= BG_IDX;
        end else begin
            sel_rgb <= win_rgb;
            sel_idx <= win_idx;
        end
    end

    // Stage 2: apply the fade level; the layer index bypasses the fade.
    always_ff @(posedge clk) begin
        if (reset) begin
            red_level   <= '0;
            green_level <= '0;
            blue_level  <= '0;
            top_layer   <= BG_IDX;
        end else begin
            red_level   <= scale(sel_rgb[RGB_W-1 -: CH_W], level);
            green_level <= scale(sel_rgb[2*CH_W-1 -: CH_W], level);
            blue_level  <= scale(sel_rgb[CH_W-1:0], level);
            top_layer   <= sel_idx;
        end
    end

    // Fade engine: the level steps only on start_of_frame, once every FADE_FRAMES frames.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            level      <= 5'd16;
            frame_cnt  <= '0;
            fade_black <= 1'b0;
            fade_done  <= 1'b0;
        end else begin
            fade_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (fade_req) begin
                        state     <= FADE_OUT;
                        frame_cnt <= '0;
                    end
                end
                FADE_OUT: begin
                    if (start_of_frame) begin
                        if (frame_cnt == CNT_LAST) begin
                            frame_cnt <= '0;
                            level     <= level - 5'd1;
                            if (level == 5'd1) begin
                                state      <= BLACK;
                                fade_black <= 1'b1;
                            end
                        end else begin
                            frame_cnt <= frame_cnt + CNT_W'(1);
                        end
                    end
                end
                BLACK: begin
                    if (fade_release) begin
                        state      <= FADE_IN;
                        frame_cnt  <= '0;
                        fade_black <= 1'b0;
                    end
                end
                FADE_IN: begin
                    if (start_of_frame) begin
                        if (frame_cnt == CNT_LAST) begin
                            frame_cnt <= '0;
                            level     <= level + 5'd1;
                            if (level == 5'd15) begin
                                state     <= IDLE;
                                fade_done <= 1'b1;
                            end
                        end else begin
                            frame_cnt <= frame_cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LAYER_COLLISION_DETECT_EN
    logic [NUM_LAYERS-1:0] coll_acc;
    logic [NUM_LAYERS-1:0] coll_hit;

    // Two or more active layers means every active layer in this pixel collided.
    assign coll_hit = (|(active & (active - NUM_LAYERS'(1)))) ? active : '0;

    // Sticky per-frame accumulator; the start_of_frame pixel belongs to the new frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            coll_acc      <= '0;
            collision_map <= '0;
        end else if (start_of_frame) begin
            collision_map <= coll_acc;
            coll_acc      <= coll_hit;
        end else begin
            coll_acc <= coll_acc | coll_hit;
        end
    end
`endif

endmodule

// File: tb/tb_layer_compositor.sv
// tb_layer_compositor: directed test of layer_compositor with default
// parameters (8 layers, 4-bit channels, 2 frames per fade step).
// Frames are kept short (FRAME_LEN cycles) so full fades finish quickly.
module tb_layer_compositor;

    localparam int NUM_LAYERS = 8;
    localparam int RGB_W      = 12;
    localparam int FRAME_LEN  = 4;

    logic                        clk = 1'b0;
    logic                        reset;
    logic                        start_of_frame;
    logic [NUM_LAYERS-1:0]       layer_dr;
    logic [NUM_LAYERS*RGB_W-1:0] layer_rgb;
    logic [RGB_W-1:0]            background_rgb;
    logic [NUM_LAYERS-1:0]       layer_en_next;
    logic                        fade_req;
    logic                        fade_release;
    logic [3:0]                  red_level;
    logic [3:0]                  green_level;
    logic [3:0]                  blue_level;
    logic [3:0]                  top_layer;
    logic                        fade_black;
    logic                        fade_done;
`ifdef LAYER_COLLISION_DETECT_EN
    logic [NUM_LAYERS-1:0]       collision_map;
`endif

    int test_count = 0;
    int fail_count = 0;
    int done_count = 0;

    layer_compositor dut (
        .clk            (clk),
        .reset          (reset),
        .start_of_frame (start_of_frame),
        .layer_dr       (layer_dr),
        .layer_rgb      (layer_rgb),
        .background_rgb (background_rgb),
        .layer_en_next  (layer_en_next),
        .fade_req       (fade_req),
        .fade_release   (fade_release),
        .red_level      (red_level),
        .green_level    (green_level),
        .blue_level     (blue_level),
        .top_layer      (top_layer),
        .fade_black     (fade_black),
        .fade_done      (fade_done)
`ifdef LAYER_COLLISION_DETECT_EN
        ,
        .collision_map  (collision_map)
`endif
    );

    always #5 clk = ~clk;

    // Advance one clock and sample 1 ns after the edge; count fade_done pulses seen.
    task automatic step();
        @(posedge clk);
        #1;
        if (fade_done) done_count++;
    endtask

    task automatic applyStimulus(input logic [7:0] dr, input logic [11:0] bg,
                                 input logic sof, input logic freq, input logic frel);
        layer_dr       = dr;
        background_rgb = bg;
        start_of_frame = sof;
        fade_req       = freq;
        fade_release   = frel;
    endtask

    task automatic checkOutput(input string tag, input logic [11:0] exp_rgb,
                               input logic [3:0] exp_top, input logic exp_black);
        test_count++;
        assert ({red_level, green_level, blue_level} === exp_rgb) else begin
            fail_count++;
            $error("FAIL %s rgb: got %h expected %h", tag, {red_level, green_level, blue_level}, exp_rgb);
        end
        test_count++;
        assert (top_layer === exp_top) else begin
            fail_count++;
            $error("FAIL %s top_layer: got %0d expected %0d", tag, top_layer, exp_top);
        end
        test_count++;
        assert (fade_black === exp_black) else begin
            fail_count++;
            $error("FAIL %s fade_black: got %b expected %b", tag, fade_black, exp_black);
        end
    endtask

    // Run n frames: start_of_frame for one cycle, then FRAME_LEN-1 quiet cycles.
    task automatic runFrames(input int n);
        for (int f = 0; f < n; f++) begin
            start_of_frame = 1'b1;
            step();
            start_of_frame = 1'b0;
            for (int c = 1; c < FRAME_LEN; c++) step();
        end
    endtask

    initial begin
        reset         = 1'b1;
        layer_rgb     = 96'h777_666_555_444_ABC_0F0_F00_00F;
        layer_en_next = 8'hFF;
        applyStimulus(8'h00, 12'h123, 1'b0, 1'b0, 1'b0);
        step();
        step();
        checkOutput("reset", 12'h000, 4'd8, 1'b0);
        test_count++;
        assert (fade_done === 1'b0) else begin
            fail_count++;
            $error("FAIL reset fade_done: got %b expected 0", fade_done);
        end

        // Background only, then layer priority with a one-cycle latency probe.
        reset = 1'b0;
        step();
        step();
        checkOutput("background", 12'h123, 4'd8, 1'b0);
        applyStimulus(8'b0000_0110, 12'h123, 1'b0, 1'b0, 1'b0);
        step();
        checkOutput("latency_1clk", 12'h123, 4'd8, 1'b0);
        step();
        checkOutput("priority_l1", 12'hF00, 4'd1, 1'b0);

        // Mask update takes effect on the start_of_frame pixel itself.
        layer_en_next = 8'b1111_1101;
        applyStimulus(8'b0000_0110, 12'h123, 1'b1, 1'b0, 1'b0);
        step();
        start_of_frame = 1'b0;
        step();
        checkOutput("mask_sof_pixel", 12'h0F0, 4'd2, 1'b0);
        applyStimulus(8'b0000_0010, 12'h123, 1'b0, 1'b0, 1'b0);
        step();
        step();
        checkOutput("masked_layer", 12'h123, 4'd8, 1'b0);
        layer_en_next = 8'hFF;
        applyStimulus(8'hFF, 12'h123, 1'b1, 1'b0, 1'b0);
        step();
        start_of_frame = 1'b0;
        step();
        checkOutput("all_draw_l0", 12'h00F, 4'd0, 1'b0);
        applyStimulus(8'b1000_0000, 12'h123, 1'b0, 1'b0, 1'b0);
        step();
        step();
        checkOutput("last_layer", 12'h777, 4'd7, 1'b0);

        // Fade-out on a constant white background.
        applyStimulus(8'h00, 12'hFFF, 1'b0, 1'b0, 1'b0);
        step();
        step();
        checkOutput("pre_fade", 12'hFFF, 4'd8, 1'b0);
        fade_req = 1'b1;
        step();
        fade_req = 1'b0;
        runFrames(1);
        checkOutput("fade_out_f1", 12'hFFF, 4'd8, 1'b0);
        runFrames(1);
        checkOutput("fade_out_f2", 12'hEEE, 4'd8, 1'b0);
        runFrames(14);
        checkOutput("fade_out_f16", 12'h777, 4'd8, 1'b0);
        runFrames(16);
        checkOutput("fade_out_f32", 12'h000, 4'd8, 1'b1);

        // In BLACK: fade_req alone is ignored; fade_req with fade_release starts fade-in.
        fade_req = 1'b1;
        step();
        fade_req = 1'b0;
        runFrames(2);
        checkOutput("black_ignores_req", 12'h000, 4'd8, 1'b1);
        done_count   = 0;
        fade_req     = 1'b1;
        fade_release = 1'b1;
        step();
        fade_req     = 1'b0;
        fade_release = 1'b0;
        checkOutput("release", 12'h000, 4'd8, 1'b0);
        runFrames(4);
        checkOutput("fade_in_f4", 12'h111, 4'd8, 1'b0);
        runFrames(6);
        fade_req = 1'b1;
        step();
        fade_req = 1'b0;
        runFrames(20);
        checkOutput("fade_in_f30", 12'hEEE, 4'd8, 1'b0);
        runFrames(2);
        checkOutput("fade_in_f32", 12'hFFF, 4'd8, 1'b0);
        test_count++;
        assert (done_count === 1) else begin
            fail_count++;
            $error("FAIL fade_done_pulses: got %0d expected 1", done_count);
        end

        // Reset in the middle of a fade-out at level 7.
        fade_req = 1'b1;
        step();
        fade_req = 1'b0;
        runFrames(18);
        checkOutput("fade_lvl7", 12'h666, 4'd8, 1'b0);
        reset = 1'b1;
        step();
        checkOutput("mid_fade_reset", 12'h000, 4'd8, 1'b0);
        reset = 1'b0;
        step();
        step();
        checkOutput("after_reset", 12'hFFF, 4'd8, 1'b0);

`ifdef LAYER_COLLISION_DETECT_EN
        // Frame N: layers 0 and 3 overlap for one pixel.
        applyStimulus(8'h00, 12'h123, 1'b1, 1'b0, 1'b0);
        step();
        start_of_frame = 1'b0;
        layer_dr = 8'b0000_1001;
        step();
        layer_dr = 8'h00;
        step();
        step();
        // Frame N+1: no overlap.
        start_of_frame = 1'b1;
        step();
        start_of_frame = 1'b0;
        test_count++;
        assert (collision_map === 8'b0000_1001) else begin
            fail_count++;
            $error("FAIL collision_n1: got %b expected 00001001", collision_map);
        end
        step();
        step();
        step();
        // Frame N+2: overlap on the start_of_frame pixel belongs to frame N+2.
        applyStimulus(8'b0000_0110, 12'h123, 1'b1, 1'b0, 1'b0);
        step();
        applyStimulus(8'h00, 12'h123, 1'b0, 1'b0, 1'b0);
        test_count++;
        assert (collision_map === 8'b0000_0000) else begin
            fail_count++;
            $error("FAIL collision_n2: got %b expected 00000000", collision_map);
        end
        step();
        step();
        step();
        start_of_frame = 1'b1;
        step();
        start_of_frame = 1'b0;
        test_count++;
        assert (collision_map === 8'b0000_0110) else begin
            fail_count++;
            $error("FAIL collision_n3: got %b expected 00000110", collision_map);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
